// File: rtl/pwm_drive.sv
// pwm_drive
// ---------
// Turns the fuzzy controller's 8-bit pulse-width command into a registered PWM
// gate drive for the fan/motor power stage. The applied duty changes only at
// PWM period boundaries, and by at most RAMP_STEP per period, so a jump in the
// command reaches the load as a soft ramp rather than a step. Dropping enable
// cuts the output off immediately; re-enabling ramps up again from zero.
//
// Parameters:
//   PRESCALE   clocks per PWM tick (1..65535); one period = 255 ticks
//   RAMP_STEP  largest change of duty_active per period (1..255)
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable        run request; low forces the output off on the next clock
//   pw            requested duty (0 = off, 255 = fully on), sampled at boundaries
//   pwm_out       registered PWM output, high while tick count < duty_active
//   duty_active   duty currently applied
//   period_start  one-clock pulse on the first clock of every PWM period
//   ramping       high while the FSM is in RAMP (duty still moving to target)

module pwm_drive #(
  parameter int PRESCALE  = 196,
  parameter int RAMP_STEP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] pw,
  output logic       pwm_out,
  output logic [7:0] duty_active,
  output logic       period_start,
  output logic       ramping
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  CNT_LAST   = 8'd254;
  localparam logic [8:0]  STEP9      = 9'(RAMP_STEP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RAMP   = 2'd1,
    STEADY = 2'd2
  } state_t;

  state_t      state_reg,   state_next;
  logic [15:0] presc_reg,   presc_next;
  logic [7:0]  cnt_reg,     cnt_next;
  logic [7:0]  duty_reg,    duty_next;
  logic [7:0]  target_reg,  target_next;
  logic        pwm_reg,     pwm_next;
  logic        ps_reg,      ps_next;
  logic        ramping_reg, ramping_next;

  logic        tick;
  logic        boundary;

  // Slew limiter signals. Nine bits so duty +/- step never wraps.
  logic [8:0]  duty9;
  logic [8:0]  pw9;
  logic [8:0]  duty_up9;
  logic [8:0]  duty_dn9;
  logic [8:0]  pw_up9;
  logic [7:0]  duty_step;

  // ---------------------------------------------------------------------------
  // Timing strobes
  // ---------------------------------------------------------------------------
  assign tick     = (presc_reg == PRESC_LAST);
  assign boundary = tick && (cnt_reg == CNT_LAST);

  // ---------------------------------------------------------------------------
  // Duty for the next period: move toward pw by at most RAMP_STEP.
  // The up/down results are only selected when they stay inside 0..255,
  // so dropping bit 8 is safe.
  // ---------------------------------------------------------------------------
  always_comb begin
    duty9    = {1'b0, duty_reg};
    pw9      = {1'b0, pw};
    duty_up9 = duty9 + STEP9;
    duty_dn9 = duty9 - STEP9;
    pw_up9   = pw9 + STEP9;
    duty_step = pw;
    if (pw9 > duty_up9) begin
      duty_step = duty_up9[7:0];
    end else if (pw_up9 < duty9) begin
      duty_step = duty_dn9[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    presc_next  = presc_reg;
    cnt_next    = cnt_reg;
    duty_next   = duty_reg;
    target_next = target_reg;
    pwm_next    = 1'b0;
    ps_next     = 1'b0;

    case (state_reg)
      IDLE: begin
        // Counters parked at zero so the first RAMP clock is tick 0 of a
        // fresh period; duty always restarts from zero (soft start).
        presc_next = '0;
        cnt_next   = '0;
        duty_next  = '0;
        if (enable) begin
          state_next  = RAMP;
          target_next = pw;
          ps_next     = 1'b1;
        end
      end

      RAMP, STEADY: begin
        if (!enable) begin
          // Hard cut-off; takes priority over a coincident boundary.
          state_next = IDLE;
          presc_next = '0;
          cnt_next   = '0;
          duty_next  = '0;
        end else begin
          pwm_next   = (cnt_reg < duty_reg);
          presc_next = tick ? 16'd0 : presc_reg + 16'd1;
          if (tick) begin
            cnt_next = (cnt_reg == CNT_LAST) ? 8'd0 : cnt_reg + 8'd1;
          end
          if (boundary) begin
            target_next = pw;
            duty_next   = duty_step;
            ps_next     = 1'b1;
            state_next  = (duty_step == pw) ? STEADY : RAMP;
          end
        end
      end

      default: begin
        state_next = IDLE;
        presc_next = '0;
        cnt_next   = '0;
        duty_next  = '0;
      end
    endcase

    // Registered view of the state being entered, so it drops on the same
    // clock that duty_active lands on the target.
    ramping_next = (state_next == RAMP);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      presc_reg   <= '0;
      cnt_reg     <= '0;
      duty_reg    <= '0;
      target_reg  <= '0;
      pwm_reg     <= 1'b0;
      ps_reg      <= 1'b0;
      ramping_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      presc_reg   <= presc_next;
      cnt_reg     <= cnt_next;
      duty_reg    <= duty_next;
      target_reg  <= target_next;
      pwm_reg     <= pwm_next;
      ps_reg      <= ps_next;
      ramping_reg <= ramping_next;
    end
  end

  assign pwm_out      = pwm_reg;
  assign duty_active  = duty_reg;
  assign period_start = ps_reg;
  assign ramping      = ramping_reg;

endmodule

// File: tb/tb_pwm_drive.sv
// Testbench for pwm_drive (PRESCALE=2, RAMP_STEP=4).
// Stimulus runs whole PWM periods, predicting each period's duty and ramping
// flag from the slew rule and pushing them into exp_q; direct output snapshots
// go to snap_q. A negedge monitor pops and compares.

module tb_pwm_drive;

  localparam int PRESCALE  = 2;
  localparam int RAMP_STEP = 4;
  localparam int P         = 255 * PRESCALE;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] pw;
  logic       pwm_out;
  logic [7:0] duty_active;
  logic       period_start;
  logic       ramping;

  pwm_drive #(
    .PRESCALE (PRESCALE),
    .RAMP_STEP(RAMP_STEP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .pw          (pw),
    .pwm_out     (pwm_out),
    .duty_active (duty_active),
    .period_start(period_start),
    .ramping     (ramping)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int duty;
    bit ramping;
    bit chk_prev;
  } exp_t;

  typedef struct {
    string    name;
    bit [3:0] mask;   // {ramping, period_start, duty, pwm}
    bit       pwm;
    int       duty;
    bit       ps;
    bit       ramp;
  } snap_t;

  exp_t  exp_q[$];
  snap_t snap_q[$];

  bit mon_on;
  bit done;
  int m_duty;

  // Monitor-owned state
  int    total;
  int    bad;
  int    hi_acc;
  int    ref_duty;
  bit    ref_ramp;
  bit    have_ref;
  exp_t  e_m;
  snap_t s_m;

  initial begin
    mon_on = 1'b0;
    done   = 1'b0;
    total  = 0;
    bad    = 0;
    hi_acc = 0;
    ref_duty = 0;
    ref_ramp = 1'b0;
    have_ref = 1'b0;
  end

  // Slew rule: clamp the move toward p to RAMP_STEP.
  function automatic int next_duty(input int d, input int p);
    if (p > d) return (p < d + RAMP_STEP) ? p : d + RAMP_STEP;
    return (p > d - RAMP_STEP) ? p : d - RAMP_STEP;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (snap_q.size() > 0) begin
      s_m = snap_q.pop_front();
      if (s_m.mask[0]) check({s_m.name, "_pwm"},     int'(pwm_out),      int'(s_m.pwm));
      if (s_m.mask[1]) check({s_m.name, "_duty"},    int'(duty_active),  s_m.duty);
      if (s_m.mask[2]) check({s_m.name, "_pstart"},  int'(period_start), int'(s_m.ps));
      if (s_m.mask[3]) check({s_m.name, "_ramping"}, int'(ramping),      int'(s_m.ramp));
    end

    if (mon_on) begin
      if (period_start) begin
        if (exp_q.size() == 0) begin
          check("period_start_unexpected", int'(period_start), 0);
        end else begin
          e_m = exp_q.pop_front();
          if (e_m.chk_prev && have_ref)
            check("high_time", hi_acc + int'(pwm_out), ref_duty * PRESCALE);
          check("duty_at_period", int'(duty_active), e_m.duty);
          check("ramping_at_period", int'(ramping), int'(e_m.ramping));
          ref_duty = e_m.duty;
          ref_ramp = e_m.ramping;
          have_ref = 1'b1;
          hi_acc   = 0;
        end
      end else if (have_ref) begin
        hi_acc += int'(pwm_out);
        check("duty_frozen", int'(duty_active), ref_duty);
        check("ramping_frozen", int'(ramping), int'(ref_ramp));
      end
    end else begin
      have_ref = 1'b0;
    end

    if (done) begin
      check("exp_queue_drained", exp_q.size(), 0);
      check("snap_queue_drained", snap_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic run_clocks(input int n);
    for (int i = 0; i < n; i++) tick_clk();
  endtask

  task automatic snap(input string name, input bit [3:0] mask, input bit p,
                      input int d, input bit s, input bit r);
    snap_q.push_back('{name: name, mask: mask, pwm: p, duty: d, ps: s, ramp: r});
  endtask

  task automatic snap_zero(input string name);
    snap(name, 4'b1111, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Called with the DUT in IDLE; the next edge enters RAMP with duty 0.
  task automatic start_run(input logic [7:0] v);
    pw     = v;
    enable = 1'b1;
    m_duty = 0;
    exp_q.push_back('{duty: 0, ramping: 1'b1, chk_prev: 1'b0});
    mon_on = 1'b1;
    tick_clk();
  endtask

  // One full period starting at its first clock; pw goes to pa at tick ca and
  // to pb at tick cb. Whatever pw is on the last clock is what gets applied.
  task automatic run_period(input logic [7:0] pa, input int ca,
                            input logic [7:0] pb, input int cb);
    int nd;
    for (int c = 0; c < P; c++) begin
      if (c == ca * PRESCALE) pw = pa;
      if (c == cb * PRESCALE) pw = pb;
      if (c == P - 1) begin
        nd = next_duty(m_duty, int'(pw));
        exp_q.push_back('{duty: nd, ramping: (nd != int'(pw)), chk_prev: 1'b1});
        m_duty = nd;
      end
      tick_clk();
    end
  endtask

  task automatic run_until_steady(input logic [7:0] v, input int extra);
    while (m_duty != int'(v)) run_period(v, 0, v, 0);
    for (int i = 0; i < extra; i++) run_period(v, 0, v, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] pa, pb;
    int ca, cb;

    rst_n  = 1'b1;
    enable = 1'b0;
    pw     = 8'd0;
    m_duty = 0;
    #1 rst_n = 1'b0;

    // Reset held over three clock edges
    tick_clk(); snap_zero("reset0");
    tick_clk(); snap_zero("reset1");
    tick_clk();
    rst_n = 1'b1;
    snap_zero("idle_after_reset");

    // Soft start to 20: 0,4,8,12,16,20 then steady (40 high clocks per period)
    start_run(8'd20);
    run_until_steady(8'd20, 3);

    // Full on: ramp to 255 and hold three periods
    run_until_steady(8'd255, 3);

    // Begin ramping down, then async reset at tick 77 of the next period
    run_period(8'd10, 0, 8'd10, 0);
    run_clocks(153);
    snap("pre_reset", 4'b1111, 1'b1, 251, 1'b0, 1'b1);
    tick_clk();
    mon_on = 1'b0;
    #1 rst_n = 1'b0;
    snap_zero("async_reset");
    tick_clk();
    tick_clk();
    rst_n = 1'b1;                 // enable still high
    snap_zero("idle_after_release");
    start_run(8'd10);

    // 0,4,8,10 then down to 0: 6,2,0 and hold
    run_until_steady(8'd10, 0);
    run_until_steady(8'd0, 2);

    // Mid-period command changes are ignored; only the boundary value counts
    run_until_steady(8'd100, 1);
    run_period(8'd200, 50, 8'd102, 200);
    run_period(8'd102, 0, 8'd102, 0);

    // Disable mid-period at tick 30 with duty 128
    run_until_steady(8'd128, 1);
    run_clocks(60);
    snap("pre_disable", 4'b1111, 1'b1, 128, 1'b0, 1'b0);
    mon_on = 1'b0;
    enable = 1'b0;
    tick_clk();
    snap_zero("disable_cutoff");
    tick_clk();
    start_run(8'd60);
    run_period(8'd60, 0, 8'd60, 0);
    run_period(8'd60, 0, 8'd60, 0);
    run_period(8'd60, 0, 8'd60, 0);

    // Disable coinciding with a boundary: no period_start, duty goes to 0
    run_clocks(P - 1);
    mon_on = 1'b0;
    enable = 1'b0;
    tick_clk();
    snap_zero("disable_at_boundary");
    tick_clk();

    // Random commands with random mid-period changes
    start_run(8'($urandom_range(0, 255)));
    for (int i = 0; i < 6; i++) begin
      pa = 8'($urandom_range(0, 255));
      pb = 8'($urandom_range(0, 255));
      ca = $urandom_range(0, 254);
      cb = $urandom_range(ca, 254);
      run_period(pa, ca, pb, cb);
    end

    done = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
